gpio_pad_ctrl: RTL

- Per-pad control block driving the pc3b03ed bidirectional pad wrapper: produces OUT, OUT_EN_N, INPUT_DIS and dm[2:0], and returns the pad's IN to the core.
- Configuration arrives over a daisy-chained serial shift bus from housekeeping.
- A verified load strobe transfers the shifted word into the active configuration.
- Selects management or user control of the pad, supports output hold, and synchronises pad input into the clock domain.

---
 rtl/gpio_pad_ctrl.sv | 69 ++++++
 1 files changed

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: per-pad control with serial-loaded config, mgmt/user select, output hold and input sync
module gpio_pad_ctrl #(
  parameter int CFG_W = 7,
  parameter logic [CFG_W-1:0] CFG_DEFAULT = 7'h0B
) (
  input  logic       serial_clock,
  input  logic       resetn,
  input  logic       serial_data_in,
  input  logic       serial_shift,
  input  logic       serial_load,
  output logic       serial_data_out,
  output logic       cfg_err,
  input  logic       mgmt_gpio_out,
  input  logic       mgmt_gpio_oeb,
  output logic       mgmt_gpio_in,
  input  logic       user_gpio_out,
  input  logic       user_gpio_oeb,
  output logic       user_gpio_in,
  input  logic       pad_in,
  output logic       pad_out,
  output logic       pad_out_en_n,
  output logic       pad_input_dis,
  output logic [2:0] pad_dm
);
  logic [CFG_W-1:0] shift_q, shift_d, cfg_q, cfg_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] sync_q, sync_d;
  logic err_q, err_d, out_q, out_d, oen_q, oen_d;
  logic load_ok, src_out, src_oeb;
  always_comb begin
    load_ok = serial_load && cnt_q == 4'(CFG_W);
    shift_d = (serial_shift && !serial_load) ? {shift_q[CFG_W-2:0], serial_data_in} : shift_q;
    cnt_d   = serial_load ? 4'd0 : (serial_shift && cnt_q != 4'(CFG_W + 1)) ? cnt_q + 4'd1 : cnt_q;
    cfg_d   = load_ok ? shift_q : cfg_q;
    err_d   = serial_load ? !load_ok : err_q;
    src_out = cfg_q[0] ? mgmt_gpio_out : user_gpio_out;
    src_oeb = cfg_q[0] ? mgmt_gpio_oeb : user_gpio_oeb;
    out_d   = cfg_q[6] ? out_q : src_out;
    oen_d   = cfg_q[6] ? oen_q : (src_oeb | cfg_q[1]);
    sync_d  = {sync_q[0], pad_in};
  end
  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      shift_q <= '0;
      cnt_q   <= '0;
      cfg_q   <= CFG_DEFAULT;
      err_q   <= 1'b0;
      out_q   <= 1'b0;
      oen_q   <= 1'b1;
      sync_q  <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      err_q   <= err_d;
      out_q   <= out_d;
      oen_q   <= oen_d;
      sync_q  <= sync_d;
    end
  end
  assign serial_data_out = shift_q[CFG_W-1];
  assign cfg_err         = err_q;
  assign pad_out         = out_q;
  assign pad_out_en_n    = oen_q;
  assign pad_input_dis   = cfg_q[2];
  assign pad_dm          = cfg_q[5:3];
  assign mgmt_gpio_in    = sync_q[1] & cfg_q[0] & ~cfg_q[2];
  assign user_gpio_in    = sync_q[1] & ~cfg_q[0] & ~cfg_q[2];
endmodule
